// File: rtl/sim_mem_pkg.sv
// rtl/sim_mem_pkg.sv - shared types and constants for the simulation memory
package sim_mem_pkg;

  localparam int SIM_MEM_MAX_LAT = 4;
  localparam int SIM_MEM_MAX_DW  = 64;
  localparam logic [31:0] SIM_MEM_EXIT_ADDR = 32'hFFFF_FFF0;

  // Response entry carried through the pipeline and the response FIFO.
  typedef struct packed {
    logic                      err;
    logic [SIM_MEM_MAX_DW-1:0] rdata;
  } sim_mem_ent_t;

endpackage

// File: rtl/sim_rsp_fifo.sv
// rtl/sim_rsp_fifo.sv - synchronous response FIFO of sim_mem_ent_t
// No bypass: an entry pushed into an empty FIFO appears at the head one cycle later.
module sim_rsp_fifo
  import sim_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  sim_mem_ent_t ent_i,
  input  logic         pop_i,
  output sim_mem_ent_t ent_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  sim_mem_ent_t  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = ptr_inc(wptr_q);
    if (do_pop)  rptr_d = ptr_inc(rptr_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= ent_i;
  end

  // Stale storage is masked so the head reads as zero whenever the FIFO is empty.
  assign ent_o   = empty ? '0 : mem_q[rptr_q];
  assign empty_o = empty;

endmodule

// File: rtl/bti_sim_mem.sv
// rtl/bti_sim_mem.sv - fixed-latency simulation memory with exit register
// Requests are credit-limited so the response FIFO can never overflow.
module bti_sim_mem
  import sim_mem_pkg::*;
#(
  parameter int             AW        = 15,
  parameter int             DW        = 32,
  parameter int             BAW       = 32,
  parameter int             LATENCY   = 1,
  parameter int             RSP_DEPTH = LATENCY + 1,
  parameter logic [BAW-1:0] EXIT_ADDR = BAW'(SIM_MEM_EXIT_ADDR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic [BAW-1:0]  req_addr,
  input  logic            req_we,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_wstrb,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            done,
  output logic [DW-1:0]   exit_code
);

  localparam int SW = DW / 8;
  localparam int IW = $clog2(RSP_DEPTH + 1);

  if (LATENCY < 1 || LATENCY > SIM_MEM_MAX_LAT || (DW % 8) != 0 || DW > SIM_MEM_MAX_DW)
  begin : g_bad_param
    $fatal(1, "bti_sim_mem: illegal LATENCY or DW");
  end

  logic [DW-1:0] data [0:(1<<AW)-1];

  logic [IW-1:0]                inflight_q, inflight_d;
  logic [LATENCY-1:0]           pv_q;
  sim_mem_ent_t [LATENCY-1:0]   pe_q;
  logic                         done_q;
  logic [DW-1:0]                exit_code_q;

  logic                         acc, pop;
  logic [AW-1:0]                widx;
  logic                         in_range, is_exit;
  sim_mem_ent_t                 ent_in, head;
  logic                         fifo_empty;
  logic                         rdata_unused;

  assign req_rdy  = !rst && (inflight_q < IW'(RSP_DEPTH));
  assign acc      = req_vld && req_rdy;
  assign pop      = rsp_vld && rsp_rdy;
  assign widx     = req_addr[AW+1:2];
  assign in_range = (req_addr[BAW-1:AW+2] == '0);
  assign is_exit  = (req_addr == EXIT_ADDR);

  // Response payload is resolved at acceptance; writes always return zero data.
  always_comb begin
    ent_in = '0;
    if (is_exit) begin
      if (!req_we) ent_in.rdata = SIM_MEM_MAX_DW'(exit_code_q);
    end else if (!in_range) begin
      ent_in.err = 1'b1;
    end else if (!req_we) begin
      ent_in.rdata = SIM_MEM_MAX_DW'(data[widx]);
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (acc && !pop)      inflight_d = inflight_q + 1'b1;
    else if (!acc && pop) inflight_d = inflight_q - 1'b1;
  end

  // Array is deliberately never reset so preloaded contents and earlier writes survive.
  always @(posedge clk) begin
    if (acc && req_we && in_range && !is_exit) begin
      for (int i = 0; i < SW; i++) begin
        if (req_wstrb[i]) data[widx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q  <= '0;
      pv_q        <= '0;
      pe_q        <= '0;
      done_q      <= 1'b0;
      exit_code_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      pv_q[0]    <= acc;
      pe_q[0]    <= ent_in;
      for (int i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
      if (acc && req_we && is_exit) begin
        done_q      <= 1'b1;
        exit_code_q <= req_wdata;
      end
    end
  end

  sim_rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (pv_q[LATENCY-1]),
    .ent_i  (pe_q[LATENCY-1]),
    .pop_i  (rsp_rdy),
    .ent_o  (head),
    .empty_o(fifo_empty)
  );

  assign rsp_vld      = !fifo_empty;
  assign rsp_rdata    = head.rdata[DW-1:0];
  assign rsp_err      = head.err;
  assign rdata_unused = ^head.rdata;
  assign done         = done_q;
  assign exit_code    = exit_code_q;

endmodule

// File: tb/tb_bti_sim_mem.sv
// tb/tb_bti_sim_mem.sv - scoreboard bench for bti_sim_mem at LATENCY=2
module tb_bti_sim_mem;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        done;
  logic [31:0] exit_code;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   rsp_cycs[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_rsp = 0;
  int   acc_cyc = 0;
  exp_t mon_e;

  bti_sim_mem #(.AW(15), .DW(32), .BAW(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .done(done), .exit_code(exit_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_vld && rsp_rdy) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", rsp_err, mon_e.err);
      end
      rsp_cycs.push_back(cyc);
      n_rsp++;
    end
  end

  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic err, input logic [31:0] rdata);
    int   n;
    exp_t e;
    req_vld = 1'b1; req_addr = addr; req_we = we; req_wdata = wdata; req_wstrb = wstrb;
    n = 0;
    @(negedge clk);
    while (!req_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!req_rdy) begin
      check("req_rdy_timeout", req_rdy, 1);
      req_vld = 1'b0;
    end else begin
      @(posedge clk);
      e.err = err; e.rdata = rdata;
      sb.push_back(e);
      #1;
      req_vld = 1'b0;
      acc_cyc = cyc;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_vld) && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n0;
    dut.data[0] = 32'h0000_0013;
    dut.data[1] = 32'h0010_0093;
    dut.data[2] = 32'h1122_3344;
    dut.data[3] = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_done", done, 0);
    check("rst_exit_code", exit_code, 0);
    check("rst_req_rdy", req_rdy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_rdy", req_rdy, 1);
    @(posedge clk); #1;

    // Back-to-back reads: responses at t+2 and t+3.
    rsp_cycs.delete();
    issue(32'h0, 1'b0, 0, 4'h0, 1'b0, 32'h0000_0013);
    t0 = acc_cyc;
    issue(32'h4, 1'b0, 0, 4'h0, 1'b0, 32'h0010_0093);
    wait_idle();
    check("b2b_count", rsp_cycs.size(), 2);
    if (rsp_cycs.size() == 2) begin
      check("b2b_lat0", rsp_cycs[0], t0 + LAT);
      check("b2b_lat1", rsp_cycs[1], t0 + LAT + 1);
    end

    // Byte-strobed write immediately followed by a read of the same word.
    issue(32'h8, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0);
    issue(32'h8, 1'b0, 0, 4'h0, 1'b0, 32'h11BB_33DD);
    wait_idle();

    // Out-of-range accesses have no side effect; this address aliases word 0.
    issue(32'h0010_0000, 1'b0, 0, 4'h0, 1'b1, 32'h0);
    issue(32'h0010_0000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0);
    issue(32'h0, 1'b0, 0, 4'h0, 1'b0, 32'h0000_0013);
    wait_idle();

    // Back-pressure: three credits, then req_rdy drops and the head holds.
    n0 = n_rsp;
    rsp_rdy = 1'b0;
    issue(32'h0, 1'b0, 0, 4'h0, 1'b0, 32'h0000_0013);
    issue(32'h4, 1'b0, 0, 4'h0, 1'b0, 32'h0010_0093);
    issue(32'h8, 1'b0, 0, 4'h0, 1'b0, 32'h11BB_33DD);
    @(negedge clk);
    check("bp_req_rdy_low", req_rdy, 0);
    repeat (4) @(negedge clk);
    check("bp_rsp_vld", rsp_vld, 1);
    check("bp_head_hold", rsp_rdata, 32'h0000_0013);
    check("bp_req_rdy_still_low", req_rdy, 0);
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    issue(32'hC, 1'b0, 0, 4'h0, 1'b0, 32'hCAFE_F00D);
    wait_idle();
    check("bp_rsp_count", n_rsp - n0, 4);

    // Exit register: strobes are ignored and done is sticky.
    issue(32'hFFFF_FFF0, 1'b1, 32'h1, 4'hF, 1'b0, 32'h0);
    check("exit_done", done, 1);
    check("exit_code1", exit_code, 1);
    issue(32'hFFFF_FFF0, 1'b0, 0, 4'h0, 1'b0, 32'h1);
    issue(32'hFFFF_FFF0, 1'b1, 32'h5, 4'h0, 1'b0, 32'h0);
    check("exit_done_sticky", done, 1);
    check("exit_code5", exit_code, 5);
    wait_idle();

    // Reset with three responses queued.
    rsp_rdy = 1'b0;
    issue(32'hC, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
    issue(32'h0, 1'b0, 0, 4'h0, 1'b0, 32'h0000_0013);
    issue(32'h4, 1'b0, 0, 4'h0, 1'b0, 32'h0010_0093);
    repeat (4) @(negedge clk);
    check("mid_rsp_vld_before", rsp_vld, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    n0 = n_rsp;
    @(negedge clk);
    check("mid_req_rdy_in_rst", req_rdy, 0);
    @(negedge clk);
    check("mid_rsp_vld", rsp_vld, 0);
    check("mid_rsp_rdata", rsp_rdata, 0);
    check("mid_done", done, 0);
    check("mid_exit_code", exit_code, 0);
    check("mid_req_rdy_in_rst2", req_rdy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_rdy = 1'b1;
    @(negedge clk);
    check("mid_req_rdy_after", req_rdy, 1);
    repeat (5) @(negedge clk);
    check("mid_no_stale_rsp", n_rsp - n0, 0);
    @(posedge clk); #1;
    issue(32'hC, 1'b0, 0, 4'h0, 1'b0, 32'h1234_5678);
    issue(32'h8, 1'b0, 0, 4'h0, 1'b0, 32'h11BB_33DD);
    wait_idle();
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
